baud_gen: RTL and testbench

- Parametrised successor to the fixed divide-by-2 clock divider.
- Generates an oversample tick, a bit-rate tick and a ~50% duty bit-rate clock from the 50 MHz system clock.
- Divisor is runtime-programmable through a shadow-register load handshake that applies only at tick boundaries, so no glitches occur.
- Feeds the RS-485 transmitter and receiver: the receiver uses ovs_tick for sampling, the transmitter uses bit_tick.

---
 rtl/baud_pkg.sv | 16 +
 rtl/baud_prescaler.sv | 85 ++++++++
 rtl/baud_gen.sv | 89 ++++++++
 tb/tb_baud_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared constants for the baud generator.
// Default counter width, oversample ratio and 50 MHz divisors for common
// bit rates at 16x oversampling.
package baud_pkg;

  localparam int unsigned CntWDef   = 16;
  localparam int unsigned OvsDef    = 16;

  // 50 MHz / (rate * 16), rounded
  localparam int unsigned Div9600   = 326;
  localparam int unsigned Div19200  = 163;
  localparam int unsigned Div115200 = 27;

  localparam int unsigned DefDivDef = Div115200;

endpackage

// File: rtl/baud_prescaler.sv
// Programmable prescaler: down-counter producing ovs_tick, plus the shadow
// divisor register and its apply/acknowledge handshake.
// Ports:
//   clk50    - system clock
//   rst      - synchronous active-high reset
//   en       - run enable; low holds the counter at its reload value
//   div_val  - new divisor value
//   div_load - strobe capturing div_val into the shadow register
//   div_ack  - pulse in the cycle the shadow divisor becomes active
//   div_pend - a loaded divisor is waiting to be applied
//   div_cur  - currently active divisor
//   ovs_tick - one-cycle pulse every max(div_cur,1) cycles
module baud_prescaler
  import baud_pkg::*;
#(
  parameter int unsigned CNT_W   = CntWDef,
  parameter int unsigned DEF_DIV = DefDivDef
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_pend,
  output logic [CNT_W-1:0] div_cur,
  output logic             ovs_tick
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  // Divisors 0 and 1 both mean "tick every cycle", so both reload to 0.
  function automatic logic [CNT_W-1:0] reload_of(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - One;
  endfunction

  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             tick, apply;
  logic [CNT_W-1:0] new_div;

  always_comb begin
    tick     = en && (pre_cnt_q == '0);
    // A load in the apply cycle bypasses the shadow so the newest value wins.
    new_div  = div_load ? div_val : shadow_q;
    apply    = en ? (tick && (pend_q || div_load)) : pend_q;
    div_cur_d = apply ? new_div : div_cur_q;
    shadow_d = div_load ? div_val : shadow_q;

    pend_d = pend_q;
    if (apply) begin
      pend_d = 1'b0;
    end else if (div_load) begin
      pend_d = 1'b1;
    end

    pre_cnt_d = pre_cnt_q - One;
    if (!en || tick) begin
      pre_cnt_d = reload_of(div_cur_d);
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      pre_cnt_q <= reload_of(DefDiv);
      div_cur_q <= DefDiv;
      shadow_q  <= DefDiv;
      pend_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      div_cur_q <= div_cur_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
    end
  end

  assign div_ack  = apply;
  assign div_pend = pend_q;
  assign div_cur  = div_cur_q;
  assign ovs_tick = tick;

endmodule

// File: rtl/baud_gen.sv
// Baud generator: prescaled oversample tick, bit-rate tick and a ~50% duty
// bit-rate clock, with a runtime-programmable divisor.
// Ports:
//   clk50    - 50 MHz system clock
//   rst      - synchronous active-high reset
//   en       - run enable; low idles and phase-clears the generator
//   div_val  - new divisor value
//   div_load - strobe capturing div_val into the shadow register
//   div_ack  - pulse in the cycle the shadow divisor becomes active
//   div_pend - a loaded divisor is waiting to be applied
//   div_cur  - currently active divisor
//   ovs_tick - oversample tick (receiver sampling)
//   bit_tick - bit tick, every OVS-th ovs_tick (transmitter)
//   clk_out  - bit-rate clock, rises mid-bit, falls at bit boundary
module baud_gen
  import baud_pkg::*;
#(
  parameter int unsigned CNT_W   = CntWDef,
  parameter int unsigned OVS     = OvsDef,
  parameter int unsigned DEF_DIV = DefDivDef
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_pend,
  output logic [CNT_W-1:0] div_cur,
  output logic             ovs_tick,
  output logic             bit_tick,
  output logic             clk_out
);

  localparam int unsigned    OvsW    = $clog2(OVS);
  localparam logic [OvsW-1:0] LastIdx = OvsW'(OVS - 1);
  localparam logic [OvsW-1:0] MidIdx  = OvsW'(OVS / 2 - 1);

  logic [OvsW-1:0] ovs_cnt_q, ovs_cnt_d;
  logic            clk_q, clk_d;
  logic            at_mid, at_last;

  baud_prescaler #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) u_prescaler (
    .clk50    (clk50),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_pend (div_pend),
    .div_cur  (div_cur),
    .ovs_tick (ovs_tick)
  );

  always_comb begin
    at_mid   = (ovs_cnt_q == MidIdx);
    at_last  = (ovs_cnt_q == LastIdx);
    bit_tick = ovs_tick && at_last;

    ovs_cnt_d = ovs_cnt_q;
    clk_d     = clk_q;
    if (!en) begin
      ovs_cnt_d = '0;
      clk_d     = 1'b0;
    end else if (ovs_tick) begin
      ovs_cnt_d = at_last ? '0 : ovs_cnt_q + OvsW'(1);
      if (at_mid || at_last) begin
        clk_d = ~clk_q;
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      ovs_cnt_q <= '0;
      clk_q     <= 1'b0;
    end else begin
      ovs_cnt_q <= ovs_cnt_d;
      clk_q     <= clk_d;
    end
  end

  // Gated so the clock reads low in the very cycle en drops.
  assign clk_out = clk_q & en;

endmodule

// File: tb/tb_baud_gen.sv
// Directed self-checking bench for baud_gen at default parameters
// (CNT_W=16, OVS=16, DEF_DIV=27).
module tb_baud_gen;

  logic        clk50 = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div_val = '0;
  logic        div_load = 1'b0;
  logic        div_ack, div_pend, ovs_tick, bit_tick, clk_out;
  logic [15:0] div_cur;

  int checks = 0;
  int errors = 0;

  // Per-run observations; *_first are 1-based cycle indices, 0 = never.
  int ovs_n, bit_n, ack_n, pend_n, clk_hi;
  int ovs_first, bit_first, ack_first, clk_first;
  logic [15:0] last_div_cur;
  logic        last_pend, last_ack, last_ovs, last_bit, last_clk;

  always #10 clk50 = ~clk50;

  baud_gen u_dut (
    .clk50    (clk50),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_pend (div_pend),
    .div_cur  (div_cur),
    .ovs_tick (ovs_tick),
    .bit_tick (bit_tick),
    .clk_out  (clk_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("assertion on %s", tag);
    end
  endtask

  // Run n cycles from posedge+1, sampling outputs at each negedge.
  task automatic run(input int n);
    ovs_n = 0; bit_n = 0; ack_n = 0; pend_n = 0; clk_hi = 0;
    ovs_first = 0; bit_first = 0; ack_first = 0; clk_first = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk50);
      if (ovs_tick) begin ovs_n++; if (ovs_first == 0) ovs_first = i; end
      if (bit_tick) begin bit_n++; if (bit_first == 0) bit_first = i; end
      if (div_ack)  begin ack_n++; if (ack_first == 0) ack_first = i; end
      if (clk_out)  begin clk_hi++; if (clk_first == 0) clk_first = i; end
      if (div_pend) pend_n++;
      last_div_cur = div_cur; last_pend = div_pend; last_ack = div_ack;
      last_ovs = ovs_tick; last_bit = bit_tick; last_clk = clk_out;
      @(posedge clk50);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] v);
    div_val = v;
    div_load = 1'b1;
    run(1);
    div_load = 1'b0;
  endtask

  initial begin
    // Reset for 3 edges, then enable.
    repeat (3) @(posedge clk50);
    #1;
    rst = 1'b0;
    en = 1'b1;
    run(1);
    check("rst_div_cur", 32'(last_div_cur), 32'd27);
    check("rst_pend", 32'(last_pend), 32'd0);
    check("rst_ack", 32'(last_ack), 32'd0);
    check("rst_ovs", 32'(last_ovs), 32'd0);
    check("rst_bit", 32'(last_bit), 32'd0);
    check("rst_clk", 32'(last_clk), 32'd0);
    run(863);  // cycles 2..864 of the first two bits
    check("def_ovs_first", ovs_first, 26);
    check("def_ovs_n", ovs_n, 32);
    check("def_bit_first", bit_first, 431);
    check("def_bit_n", bit_n, 2);
    check("def_clk_first", clk_first, 216);
    check("def_clk_hi", clk_hi, 432);

    // Mid-count load of 10 when pre_cnt==15.
    run(11);
    load(16'd10);
    run(15);
    check("mid_pend_n", pend_n, 15);
    check("mid_ack_first", ack_first, 15);
    check("mid_ack_n", ack_n, 1);
    check("mid_ovs_first", ovs_first, 15);
    check("mid_div_cur", 32'(div_cur), 32'd10);
    run(30);
    check("mid_period_first", ovs_first, 10);
    check("mid_period_n", ovs_n, 3);
    check("mid_period_ack", ack_n, 0);

    // Double load: 50 then 8 before the tick; next tick is 6 cycles later.
    load(16'd50);
    run(2);
    load(16'd8);
    run(6);
    check("dbl_ack_n", ack_n, 1);
    check("dbl_ack_first", ack_first, 6);
    run(24);
    check("dbl_ovs_first", ovs_first, 8);
    check("dbl_ovs_n", ovs_n, 3);
    check("dbl_ack_after", ack_n, 0);
    check("dbl_div_cur", 32'(div_cur), 32'd8);

    // Load 12 exactly in the tick cycle.
    run(7);
    load(16'd12);
    check("col_ack", 32'(last_ack), 32'd1);
    check("col_ovs", 32'(last_ovs), 32'd1);
    run(24);
    check("col_ovs_first", ovs_first, 12);
    check("col_ovs_n", ovs_n, 2);
    check("col_div_cur", 32'(div_cur), 32'd12);
    check("col_pend", 32'(div_pend), 32'd0);

    // Divisor 0: applied at the next tick (11 cycles), then tick every cycle.
    load(16'd0);
    run(11);
    check("d0_ack_first", ack_first, 11);
    run(32);
    check("d0_ovs_n", ovs_n, 32);
    check("d0_bit_n", bit_n, 2);
    check("d0_div_cur", 32'(div_cur), 32'd0);

    // Divisor 1: every cycle is a tick, so it applies immediately.
    load(16'd1);
    check("d1_ack", 32'(last_ack), 32'd1);
    run(32);
    check("d1_ovs_n", ovs_n, 32);
    check("d1_bit_n", bit_n, 2);
    check("d1_div_cur", 32'(div_cur), 32'd1);

    // Restore 27 while disabled, then run 12 ticks (past mid-bit).
    en = 1'b0;
    load(16'd27);
    run(1);
    check("dis27_ack_first", ack_first, 1);
    en = 1'b1;
    run(324);
    check("en27_ovs_first", ovs_first, 27);
    check("en27_ovs_n", ovs_n, 12);
    check("en27_clk_first", clk_first, 217);
    check("en27_clk_last", 32'(last_clk), 32'd1);

    // Disable for 100 cycles mid-bit, loading 5 along the way.
    en = 1'b0;
    run(50);
    check("dis_a_ovs_n", ovs_n, 0);
    check("dis_a_clk_hi", clk_hi, 0);
    load(16'd5);
    run(1);
    check("dis_ack_first", ack_first, 1);
    check("dis_ack_n", ack_n, 1);
    run(48);
    check("dis_b_ovs_n", ovs_n, 0);
    check("dis_b_bit_n", bit_n, 0);
    check("dis_b_clk_hi", clk_hi, 0);
    check("dis_div_cur", 32'(div_cur), 32'd5);
    en = 1'b1;
    run(10);
    check("reen_ovs_first", ovs_first, 5);
    check("reen_ovs_n", ovs_n, 2);

    // Reset at ovs_cnt==9 with a load pending.
    run(35);
    check("pre_rst_ovs_n", ovs_n, 7);
    load(16'd100);
    rst = 1'b1;
    run(1);
    check("pre_rst_pend", 32'(last_pend), 32'd1);
    rst = 1'b0;
    run(1);
    check("mrst_div_cur", 32'(last_div_cur), 32'd27);
    check("mrst_pend", 32'(last_pend), 32'd0);
    check("mrst_ack", 32'(last_ack), 32'd0);
    check("mrst_ovs", 32'(last_ovs), 32'd0);
    check("mrst_bit", 32'(last_bit), 32'd0);
    check("mrst_clk", 32'(last_clk), 32'd0);
    run(26);
    check("mrst_ovs_first", ovs_first, 26);
    check("mrst_ack_n", ack_n, 0);
    check("mrst_pend_n", pend_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
